// File: rtl/seg7_disp_ctrl.sv
// CPU-facing front end for the 8-digit seven-segment driver: owns the digit-scan and blink
// timebases and double-buffers CPU writes so new values go live only at the end of a scan frame.
module seg7_disp_ctrl #(
   parameter int SCAN_DIV  = 50000,
   parameter int FLASH_DIV = 25000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [1:0]  wr_sel,
   input  logic [31:0] wr_data,
   output logic [31:0] Hexs,
   output logic [7:0]  point,
   output logic [7:0]  LES,
   output logic        SW0,
   output logic        flash,
   output logic [2:0]  Scan,
   output logic        busy,
   output logic        commit
);

   localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int FCW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
   localparam logic [SCW-1:0] SCAN_LAST  = SCW'(SCAN_DIV - 1);
   localparam logic [FCW-1:0] FLASH_LAST = FCW'(FLASH_DIV - 1);

   localparam logic [1:0] SEL_HEXS = 2'b00;
   localparam logic [1:0] SEL_PL   = 2'b01;
   localparam logic [1:0] SEL_CTRL = 2'b10;

   // timebases
   logic [SCW-1:0] scan_cnt;
   logic [FCW-1:0] flash_cnt;
   logic           flash_phase;
   logic           tick;
   logic           frame_end;

   // shadow (CPU-side) copies and their pending flags
   logic [31:0] sh_hexs;
   logic [7:0]  sh_point;
   logic [7:0]  sh_les;
   logic [1:0]  sh_ctrl;
   logic        pend_hexs;
   logic        pend_pl;
   logic        pend_ctrl;

   // active control register
   logic [1:0]  ctrl;

   // write decode and merged next-shadow / next-pending values
   logic        wr_hexs;
   logic        wr_pl;
   logic        wr_ctrl;
   logic [31:0] nx_sh_hexs;
   logic [7:0]  nx_sh_point;
   logic [7:0]  nx_sh_les;
   logic [1:0]  nx_sh_ctrl;
   logic        nx_pend_hexs;
   logic        nx_pend_pl;
   logic        nx_pend_ctrl;
   logic        nx_any_pend;

   assign tick      = (scan_cnt == SCAN_LAST);
   assign frame_end = tick && (Scan == 3'd7);

   assign SW0   = ctrl[0];
   assign flash = flash_phase & ctrl[1];

   always_comb begin
      wr_hexs = wr_en && (wr_sel == SEL_HEXS);
      wr_pl   = wr_en && (wr_sel == SEL_PL);
      wr_ctrl = wr_en && (wr_sel == SEL_CTRL);

      nx_sh_hexs  = sh_hexs;
      nx_sh_point = sh_point;
      nx_sh_les   = sh_les;
      nx_sh_ctrl  = sh_ctrl;
      if (wr_hexs) nx_sh_hexs = wr_data;
      if (wr_pl) begin
         nx_sh_point = wr_data[7:0];
         nx_sh_les   = wr_data[15:8];
      end
      if (wr_ctrl) nx_sh_ctrl = wr_data[1:0];

      nx_pend_hexs = pend_hexs | wr_hexs;
      nx_pend_pl   = pend_pl   | wr_pl;
      nx_pend_ctrl = pend_ctrl | wr_ctrl;
      nx_any_pend  = nx_pend_hexs | nx_pend_pl | nx_pend_ctrl;
   end

   // digit-scan timebase
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt <= '0;
         Scan     <= 3'd0;
      end else if (tick) begin
         scan_cnt <= '0;
         Scan     <= Scan + 3'd1;
      end else begin
         scan_cnt <= scan_cnt + SCW'(1);
      end
   end

   // blink timebase free-runs; ctrl[1] only gates the output
   always_ff @(posedge clk) begin
      if (rst) begin
         flash_cnt   <= '0;
         flash_phase <= 1'b0;
      end else if (flash_cnt == FLASH_LAST) begin
         flash_cnt   <= '0;
         flash_phase <= ~flash_phase;
      end else begin
         flash_cnt   <= flash_cnt + FCW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sh_hexs  <= '0;
         sh_point <= '0;
         sh_les   <= '0;
         sh_ctrl  <= '0;
      end else begin
         sh_hexs  <= nx_sh_hexs;
         sh_point <= nx_sh_point;
         sh_les   <= nx_sh_les;
         sh_ctrl  <= nx_sh_ctrl;
      end
   end

   // A write landing on the frame_end edge is merged via the nx_* values and committed there.
   always_ff @(posedge clk) begin
      if (rst) begin
         Hexs      <= '0;
         point     <= '0;
         LES       <= '0;
         ctrl      <= '0;
         pend_hexs <= 1'b0;
         pend_pl   <= 1'b0;
         pend_ctrl <= 1'b0;
         busy      <= 1'b0;
         commit    <= 1'b0;
      end else if (frame_end) begin
         if (nx_pend_hexs) Hexs <= nx_sh_hexs;
         if (nx_pend_pl) begin
            point <= nx_sh_point;
            LES   <= nx_sh_les;
         end
         if (nx_pend_ctrl) ctrl <= nx_sh_ctrl;
         pend_hexs <= 1'b0;
         pend_pl   <= 1'b0;
         pend_ctrl <= 1'b0;
         busy      <= 1'b0;
         commit    <= nx_any_pend;
      end else begin
         pend_hexs <= nx_pend_hexs;
         pend_pl   <= nx_pend_pl;
         pend_ctrl <= nx_pend_ctrl;
         busy      <= nx_any_pend;
         commit    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_seg7_disp_ctrl.sv
// Bench for seg7_disp_ctrl: directed writes push the expected live register set into a queue;
// a negedge monitor pops on every commit pulse and otherwise checks that the live values hold.
module tb_seg7_disp_ctrl;

   localparam int SCAN_DIV  = 4;
   localparam int FLASH_DIV = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic [1:0]  wr_sel = 2'b00;
   logic [31:0] wr_data = 32'h0;
   logic [31:0] Hexs;
   logic [7:0]  point;
   logic [7:0]  LES;
   logic        SW0;
   logic        flash;
   logic [2:0]  Scan;
   logic        busy;
   logic        commit;

   int checks = 0;
   int errors = 0;

   // expected live set packed as {Hexs, point, LES, SW0}
   logic [48:0] exp_q[$];
   logic [48:0] live = '0;
   logic [48:0] act;
   assign act = {Hexs, point, LES, SW0};

   seg7_disp_ctrl #(.SCAN_DIV(SCAN_DIV), .FLASH_DIV(FLASH_DIV)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
      .Hexs(Hexs), .point(point), .LES(LES), .SW0(SW0), .flash(flash),
      .Scan(Scan), .busy(busy), .commit(commit)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [48:0] got, input logic [48:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [48:0] pack(input logic [31:0] h, input logic [7:0] p,
                                        input logic [7:0] l, input logic s);
      return {h, p, l, s};
   endfunction

   // scoreboard monitor
   always @(negedge clk) begin
      if (rst) begin
         live = '0;
      end else if (commit) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_commit got %0h expected no commit", act);
         end else begin
            live = exp_q.pop_front();
            check("commit_value", act, live);
         end
      end else begin
         check("hold_value", act, live);
      end
   end

   // driver tasks: all called just after a rising edge
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_write(input logic [1:0] s, input logic [31:0] d);
      wr_en   = 1'b1;
      wr_sel  = s;
      wr_data = d;
      tick();
      wr_en   = 1'b0;
      wr_sel  = 2'b00;
      wr_data = 32'h0;
   endtask

   task automatic wait_commit(input string name);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!commit && n < 80);
      check({name, "_commit"}, commit, 1'b1);
      check({name, "_busy_after"}, busy, 1'b0);
   endtask

   task automatic count_commits(input int cycles, output int c);
      c = 0;
      repeat (cycles) begin
         tick();
         if (commit) c++;
      end
   endtask

   task automatic flash_gap(output int n);
      logic p;
      p = flash;
      n = 0;
      do begin
         tick();
         n++;
      end while (flash == p && n < 40);
   endtask

   initial begin
      int n;
      int c;
      int hi;
      logic [2:0] prev;

      // reset
      tick(3);
      check("rst_hexs", Hexs, 0);
      check("rst_point", point, 0);
      check("rst_les", LES, 0);
      check("rst_sw0", SW0, 0);
      check("rst_flash", flash, 0);
      check("rst_scan", Scan, 0);
      check("rst_busy", busy, 0);
      check("rst_commit", commit, 0);
      rst = 1'b0;

      n = 0;
      do begin tick(); n++; end while (Scan != 3'd1 && n < 10);
      check("scan_first_step", n, 4);
      do begin tick(); n++; end while (Scan != 3'd0 && n < 50);
      check("scan_wrap", n, 32);

      // buffered write issued while Scan=2
      n = 0;
      while (Scan != 3'd2 && n < 40) begin tick(); n++; end
      exp_q.push_back(pack(32'h1234ABCD, 8'h00, 8'h00, 1'b0));
      do_write(2'b00, 32'h1234ABCD);
      check("buffered_busy", busy, 1'b1);
      check("buffered_hexs_not_live", Hexs, 0);
      wait_commit("buffered");

      // overwrite within one frame: last write wins, single pulse
      exp_q.push_back(pack(32'h22222222, 8'h00, 8'h00, 1'b0));
      do_write(2'b00, 32'h11111111);
      do_write(2'b00, 32'h22222222);
      wait_commit("overwrite");
      count_commits(40, c);
      check("overwrite_single_pulse", c, 0);

      // reserved select is ignored
      do_write(2'b11, 32'hFFFFFFFF);
      check("reserved_busy", busy, 1'b0);
      count_commits(40, c);
      check("reserved_no_pulse", c, 0);

      // blink enable
      exp_q.push_back(pack(32'h22222222, 8'h00, 8'h00, 1'b0));
      do_write(2'b10, 32'h00000002);
      wait_commit("ctrl_blink");
      flash_gap(n);
      flash_gap(n);
      check("flash_gap_1", n, 16);
      flash_gap(n);
      check("flash_gap_2", n, 16);

      // hex mode, blink disabled
      exp_q.push_back(pack(32'h22222222, 8'h00, 8'h00, 1'b1));
      do_write(2'b10, 32'h00000001);
      wait_commit("ctrl_hex");
      check("ctrl_hex_sw0", SW0, 1'b1);
      hi = 0;
      repeat (40) begin
         tick();
         if (flash) hi++;
      end
      check("flash_held_low", hi, 0);

      // write landing exactly on the frame_end cycle
      n = 0;
      do begin
         prev = Scan;
         tick();
         n++;
      end while (!(prev == 3'd6 && Scan == 3'd7) && n < 80);
      check("found_scan7", Scan, 3'd7);
      tick(3);
      exp_q.push_back(pack(32'h22222222, 8'h0F, 8'hF0, 1'b1));
      do_write(2'b01, 32'h0000F00F);
      check("coinc_commit", commit, 1'b1);
      check("coinc_busy", busy, 1'b0);
      check("coinc_point", point, 8'h0F);
      check("coinc_les", LES, 8'hF0);
      tick();
      check("coinc_commit_once", commit, 1'b0);
      check("coinc_busy_after", busy, 1'b0);

      // reset with a write pending discards it
      do_write(2'b00, 32'hDEADBEEF);
      check("midreset_busy_before", busy, 1'b1);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      check("midreset_hexs", Hexs, 0);
      check("midreset_busy", busy, 1'b0);
      check("midreset_point", point, 0);
      check("midreset_sw0", SW0, 1'b0);
      count_commits(40, c);
      check("midreset_no_pulse", c, 0);

      check("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg7_disp_ctrl.md
Name: seg7_disp_ctrl

Overview:
- Bus-side producer for the 8-digit seven-segment display driver: CPU writes land here, and the block generates the driver's inputs (Scan, SW0, flash, Hexs, point, LES).
- Owns the digit-scan timebase and the blink timebase.
- Double-buffers all CPU-written registers and commits them only at the end of a full 8-digit scan frame, so the display never tears mid-frame.
- Sits between the memory-mapped I/O decode and the display driver.

Parameters:
- SCAN_DIV, 50000: clk cycles per digit step (≥2).
- FLASH_DIV, 25000000: clk cycles per flash half-period (≥2).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- wr_en  input  1  write strobe, one write per asserted cycle
- wr_sel  input  2  00=Hexs, 01=point/LES, 10=control, 11=reserved
- wr_data  input  32  write data
- Hexs  output  32  active hex/segment word to driver
- point  output  8  active decimal-point enables
- LES  output  8  active per-digit blink enables
- SW0  output  1  display mode (ctrl bit0: 1=hex text, 0=raw segment)
- flash  output  1  blink phase to driver
- Scan  output  3  current digit index
- busy  output  1  a written value is pending commit
- commit  output  1  one-cycle pulse when pending values go live

Behaviour:
- Reset (rst=1 at a clk edge), takes priority over everything:
  - Hexs, point, LES, Scan, all shadows, all pending flags, both prescalers, and the flash phase flop clear to 0.
  - ctrl clears to 0, so SW0=0 and flash=0.
  - busy=0, commit=0.
  - Reset mid-frame or with pending writes discards those writes; no commit pulse follows.
- Scan timebase:
  - scan_cnt counts 0..SCAN_DIV-1; tick=1 in the cycle scan_cnt==SCAN_DIV-1.
  - On tick: scan_cnt←0 and Scan←Scan+1 (mod 8, 7 wraps to 0).
  - frame_end = tick AND Scan==7.
- Flash timebase:
  - flash_cnt counts 0..FLASH_DIV-1 independently of Scan.
  - At FLASH_DIV-1: counter←0 and phase flop toggles.
  - flash output = phase AND ctrl[1]; flash stays 0 while blink is disabled. The counter free-runs regardless of ctrl[1].
- Register mapping:
  - wr_sel 00: shadow Hexs←wr_data.
  - wr_sel 01: shadow point←wr_data[7:0], shadow LES←wr_data[15:8].
  - wr_sel 10: shadow ctrl←wr_data[1:0] (bit0→SW0, bit1=blink enable).
  - wr_sel 11: ignored; no shadow change, no pending.
  - All unused wr_data bits are ignored.
- Write handling:
  - An accepted write updates its shadow and sets that register's pending flag at the same edge.
  - A repeated write before commit overwrites the shadow; last write wins. No backpressure, writes are never refused.
  - busy = OR of pending flags, registered; it goes high the cycle after the write edge.
- Commit:
  - At frame_end, every pending register copies shadow→active, all pending flags clear, and commit=1 for exactly that next cycle.
  - No pending register means no copy and no pulse.
  - Active outputs change only at a commit edge.
- Write coinciding with frame_end: the new wr_data value is merged and committed at that same edge. Its pending flag ends cleared, and commit pulses.
- Latency: a write goes live at the first frame_end at or after the write cycle. Worst case is 8·SCAN_DIV cycles.

Test Plan:
- Reset: SCAN_DIV=4, FLASH_DIV=16, rst high 3 cycles → every output 0; after release, Scan steps 0→1 after 4 cycles and wraps 7→0 after 32 cycles.
- Buffered write: write wr_sel=00, data 32'h1234ABCD when Scan=2 → busy=1 next cycle; Hexs stays 0 until the frame_end edge, then Hexs=32'h1234ABCD with a one-cycle commit pulse and busy=0.
- Overwrite: write 00/32'h11111111, then 00/32'h22222222 in the same frame → only 32'h22222222 appears, with exactly one commit pulse; a write of wr_sel=11 gives no busy and no pulse.
- Flash: write ctrl=2'b10, wait for commit → flash toggles every 16 cycles; write ctrl=2'b01 → after the next commit flash is held 0 and SW0=1.
- Coincident write: wr_sel=01, data 32'h0000F00F in the exact frame_end cycle → point=8'h0F, LES=8'hF0 at that edge; busy stays 0 and commit pulses once.
- Reset mid-pending: write Hexs, then rst before frame_end → Hexs stays 0, busy=0, and no commit pulse in the following frame.
